// File: rtl/ts_pkg.sv
// Shared constants for the instruction memory: geometry, MIPS opcodes and the boot image.
package ts_pkg;

  localparam int IMEM_AW    = 10;
  localparam int IMEM_DW    = 32;
  localparam int IMEM_DEPTH = 1024;
  localparam int BOOT_LEN   = 6;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FN_ADDU    = 6'h21;

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {OP_SPECIAL, rs, rt, rd, 5'd0, fn};
  endfunction

  // Element 0 sits in the low bits, so the list reads bottom-up from the last word.
  localparam logic [BOOT_LEN-1:0][31:0] BOOT_IMAGE = {
    itype(OP_BEQ, 5'd0, 5'd0, 16'hFFFF),
    itype(OP_LW,  5'd0, 5'd4, 16'h0000),
    itype(OP_SW,  5'd0, 5'd3, 16'h0000),
    rtype(5'd1, 5'd2, 5'd3, FN_ADDU),
    itype(OP_ORI, 5'd0, 5'd2, 16'h0002),
    itype(OP_ORI, 5'd0, 5'd1, 16'h0001)
  };

endpackage

// File: rtl/ts_boot_rom.sv
// Combinational boot-image lookup: word at idx, or a nop beyond the end of the image.
module ts_boot_rom
  import ts_pkg::*;
#(
  parameter int AW = IMEM_AW,
  parameter int DW = IMEM_DW
) (
  input  logic [AW-1:0] idx,
  output logic [DW-1:0] word
);

  always_comb begin
    word = '0;
    for (int i = 0; i < BOOT_LEN; i++) begin
      if (idx == AW'(i)) word = DW'(BOOT_IMAGE[i]);
    end
  end

endmodule

// File: rtl/ts_instr_mem.sv
// Word-addressed instruction memory: combinational fetch port, synchronous load port,
// synchronous active-low reset that reloads the whole boot image in one edge.
module ts_instr_mem
  import ts_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = IMEM_AW,
  parameter int DW    = IMEM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] instr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] mem       [DEPTH];
  logic [DW-1:0] boot_word [DEPTH];

  // One constant-index lookup per word; these fold to constants feeding the reset mux.
  for (genvar g = 0; g < DEPTH; g++) begin : g_boot
    ts_boot_rom #(.AW(AW), .DW(DW)) u_boot_rom (
      .idx  (AW'(g)),
      .word (boot_word[g])
    );
  end

  // Reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= boot_word[i];
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign instr = mem[addr];

endmodule

// File: tb/tb_ts_instr_mem.sv
// Self-checking bench for ts_instr_mem: directed cases plus randomized traffic against an array model.
module tb_ts_instr_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  addr;
  logic [31:0] instr;
  logic        we;
  logic [9:0]  waddr;
  logic [31:0] wdata;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] refMem [1024];
  logic [31:0] bootRef [6] = '{32'h34010001, 32'h34020002, 32'h00221821,
                               32'hAC030000, 32'h8C040000, 32'h1000FFFF};

  ts_instr_mem dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .instr (instr),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Model of one rising edge given the inputs currently applied.
  task automatic modelEdge();
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) refMem[i] = (i < 6) ? bootRef[i] : 32'h0;
    end else if (we) begin
      refMem[waddr] = wdata;
    end
  endtask

  task automatic applyStimulus();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic readCheck(input string tag, input int a);
    addr = 10'(a);
    #1;
    checkOutput(tag, instr, refMem[a]);
  endtask

  task automatic writeWord(input int a, input logic [31:0] d);
    we = 1'b1; waddr = 10'(a); wdata = d;
    applyStimulus();
    we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; addr = '0; waddr = '0; wdata = '0;
    for (int i = 0; i < 1024; i++) refMem[i] = 'x;

    applyStimulus();
    rst_n = 1'b1;
    checkOutput("reset_addr0", instr, 32'h34010001);
    for (int i = 0; i < 6; i++) readCheck($sformatf("boot%0d", i), i);
    readCheck("boot6", 6);
    readCheck("boot1023", 1023);
    checkOutput("boot_const0", refMem[0], 32'h34010001);

    writeWord(10, 32'hDEADBEEF);
    readCheck("write10", 10);
    readCheck("neighbor11", 11);

    addr = 10'd3; waddr = 10'd3; wdata = 32'h12345678; we = 1'b1;
    #1;
    checkOutput("rdw_before", instr, 32'hAC030000);
    applyStimulus();
    we = 1'b0;
    checkOutput("rdw_after", instr, 32'h12345678);

    rst_n = 1'b0; we = 1'b1; waddr = 10'd0; wdata = 32'hFFFFFFFF;
    applyStimulus();
    rst_n = 1'b1; we = 1'b0;
    readCheck("reset_beats_write", 0);
    readCheck("reset_restores3", 3);

    writeWord(1023, 32'hCAFEF00D);
    readCheck("load1023", 1023);
    rst_n = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
    readCheck("reset_midload1023", 1023);
    readCheck("reset_midload10", 10);

    // Random traffic, including occasional resets and read-during-write collisions.
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 19) != 0);
      we    = $urandom_range(0, 1);
      waddr = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1)) * 10'd1023 : 10'($urandom);
      wdata = $urandom;
      addr  = ($urandom_range(0, 3) == 0) ? waddr : 10'($urandom);
      #1;
      checkOutput("rand_pre", instr, refMem[addr]);
      applyStimulus();
      checkOutput("rand_post", instr, refMem[addr]);
    end
    rst_n = 1'b1; we = 1'b0;

    for (int i = 0; i < 1024; i++) writeWord(i, 32'(i));
    for (int i = 0; i < 1024; i++) begin
      addr = 10'(i);
      #1;
      checkOutput($sformatf("sweep%0d", i), instr, 32'(i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
